// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the rv32 core: owns PC and IR and walks one
// instruction at a time through FETCH..WB. Optional MCC_ILLEGAL_TRAP_EN enables the sticky trap state.
module multicycle_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ir_o,
  input  logic        dec_valid_i,
  input  logic        dec_reg_write_i,
  input  logic        dec_mem_read_i,
  input  logic        dec_mem_write_i,
  input  logic        dec_branch_i,
  input  logic        dec_jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] target_addr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_rvalid_i,
  output logic        alu_en_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] pc_o,
  output logic [2:0]  state_o,
  output logic        retire_o,
  output logic        trap_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WAIT_I  = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WAIT_D  = 3'd5,
    S_WB      = 3'd6,
    S_TRAP    = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [31:0] pc_plus4;
  logic        is_mem;
  logic        redirect;

  // An illegal opcode that is not trapped behaves as a NOP, so it masks every
  // decoded side effect (memory access, register write, redirect).
  assign pc_plus4 = pc_q + 32'd4;
  assign is_mem   = (dec_mem_read_i | dec_mem_write_i) & ~illegal_q;
  assign redirect = ~illegal_q & (dec_jump_i | (dec_branch_i & branch_taken_i));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    alu_en_o   = 1'b0;
    rf_we_o    = 1'b0;
    wb_sel_o   = 2'b00;
    retire_o   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // Reset takes priority, so no request leaks out while rst_i is high.
        if (!halt_i && !rst_i) begin
          imem_req_o = 1'b1;
          state_d    = S_WAIT_I;
        end
      end
      S_WAIT_I: begin
        if (imem_rvalid_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal_d = ~dec_valid_i;
`ifdef MCC_ILLEGAL_TRAP_EN
        state_d   = dec_valid_i ? S_EXECUTE : S_TRAP;
`else
        state_d   = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        alu_en_o = 1'b1;
        state_d  = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_mem_write_i;
        state_d    = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (dmem_rvalid_i) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retire_o = 1'b1;
        rf_we_o  = dec_reg_write_i & ~illegal_q;
        if (!illegal_q) begin
          if (dec_jump_i) begin
            wb_sel_o = 2'b10;
          end else if (dec_mem_read_i) begin
            wb_sel_o = 2'b01;
          end
        end
        pc_d    = redirect ? target_addr_i : pc_plus4;
        state_d = S_FETCH;
      end
      S_TRAP: begin
`ifdef MCC_ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MCC_ILLEGAL_TRAP_EN
  assign trap_o = (state_q == S_TRAP);
`else
  assign trap_o = 1'b0;
`endif

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a toy decoder keyed on ir[2:0], memories with
// random wait states, and an instruction-level model of latency, strobes and next PC.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_i, halt_i;
  logic        imem_req_o, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i, ir_o;
  logic        dec_valid_i, dec_reg_write_i, dec_mem_read_i, dec_mem_write_i;
  logic        dec_branch_i, dec_jump_i, branch_taken_i;
  logic [31:0] target_addr_i;
  logic        dmem_req_o, dmem_we_o, dmem_rvalid_i;
  logic        alu_en_o, rf_we_o, retire_o, trap_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] pc_o;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_pc;

  localparam logic [31:0] RPC = 32'h0000_0100;

  multicycle_controller #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst_i), .halt_i(halt_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .ir_o(ir_o), .dec_valid_i(dec_valid_i), .dec_reg_write_i(dec_reg_write_i),
    .dec_mem_read_i(dec_mem_read_i), .dec_mem_write_i(dec_mem_write_i),
    .dec_branch_i(dec_branch_i), .dec_jump_i(dec_jump_i),
    .branch_taken_i(branch_taken_i), .target_addr_i(target_addr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
    .alu_en_o(alu_en_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .pc_o(pc_o), .state_o(state_o), .retire_o(retire_o), .trap_o(trap_o)
  );

  always #5 clk = ~clk;

  // Toy decoder. ir[2:0]: 0 ALU+wr, 1 LOAD, 2 STORE, 3 BRANCH (taken = ir[3]),
  // 4 JAL, 5 ALU no write, 6 illegal, 7 ALU+wr. Target = ir with low nibble cleared.
  always_comb begin
    dec_valid_i     = (ir_o[2:0] != 3'd6);
    dec_reg_write_i = (ir_o[2:0] == 3'd0) || (ir_o[2:0] == 3'd1) ||
                      (ir_o[2:0] == 3'd4) || (ir_o[2:0] == 3'd7);
    dec_mem_read_i  = (ir_o[2:0] == 3'd1);
    dec_mem_write_i = (ir_o[2:0] == 3'd2);
    dec_branch_i    = (ir_o[2:0] == 3'd3);
    dec_jump_i      = (ir_o[2:0] == 3'd4);
    branch_taken_i  = ir_o[3];
    target_addr_i   = ir_o & 32'hFFFF_FFF0;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Caller is positioned at the negedge of the FETCH cycle; returns at the next FETCH negedge.
  task automatic do_instr(input logic [31:0] word, input int iw, input int dw, input bit rand_halt);
    logic [2:0]  t;
    bit          mem, exp_rf, exp_we, retired;
    logic [1:0]  exp_sel;
    logic [31:0] exp_next;
    int          exp_cyc, cyc, dreq_cyc, n_imem, n_dmem, n_alu;
    t        = word[2:0];
    mem      = (t == 3'd1) || (t == 3'd2);
    exp_we   = (t == 3'd2);
    exp_rf   = (t == 3'd0) || (t == 3'd1) || (t == 3'd4) || (t == 3'd7);
    exp_sel  = (t == 3'd4) ? 2'b10 : (t == 3'd1) ? 2'b01 : 2'b00;
    if (t == 3'd4 || (t == 3'd3 && word[3])) exp_next = word & 32'hFFFF_FFF0;
    else exp_next = model_pc + 32'd4;
    exp_cyc  = 5 + iw + (mem ? 2 + dw : 0);
    dreq_cyc = -100;
    n_imem = 0; n_dmem = 0; n_alu = 0;
    retired = 1'b0;
    cyc = 1;
    while (!retired && cyc <= 40) begin
      if (cyc > 1) @(negedge clk);
      if (cyc > 1 && rand_halt) halt_i = $urandom_range(0, 1);
      imem_rvalid_i = (cyc == 2 + iw) || (cyc > 2 + iw && $urandom_range(0, 3) == 0);
      imem_rdata_i  = (cyc == 2 + iw) ? word : $urandom;
      dmem_rvalid_i = (cyc == dreq_cyc + 1 + dw);
      #1;
      if (cyc == 1) begin
        chk("fetch_req", imem_req_o, 1'b1);
        chk("fetch_addr", imem_addr_o, model_pc);
        chk("fetch_state", state_o, 3'd0);
      end else if (imem_req_o) n_imem++;
      if (dmem_req_o) begin
        n_dmem++;
        dreq_cyc = cyc;
        chk("dmem_we", dmem_we_o, exp_we);
      end
      if (alu_en_o) n_alu++;
      if (retire_o) begin
        retired = 1'b1;
        chk("retire_cycle", cyc, exp_cyc);
        chk("rf_we", rf_we_o, exp_rf);
        chk("wb_sel", wb_sel_o, exp_sel);
        chk("wb_state", state_o, 3'd6);
      end
      cyc++;
    end
    chk("retired", retired, 1'b1);
    chk("extra_imem_req", n_imem, 0);
    chk("dmem_req_count", n_dmem, mem ? 1 : 0);
    chk("alu_en_count", n_alu, 1);
    imem_rvalid_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    halt_i = 1'b0;
    model_pc = exp_next;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] t;
    rst_i = 1'b1; halt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    dmem_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", state_o, 3'd0);
    chk("rst_pc", pc_o, RPC);
    chk("rst_ir", ir_o, 32'd0);
    chk("rst_imem_req", imem_req_o, 1'b0);
    chk("rst_retire", retire_o, 1'b0);
    chk("rst_trap", trap_o, 1'b0);
    rst_i = 1'b0;
    model_pc = RPC;

    do_instr(32'h1234_5670, 0, 0, 0);          // ADDI at 0x100
    chk("next_pc_104", pc_o, 32'h104);
    do_instr(32'h0000_0011, 0, 2, 0);          // load, 3-cycle data wait
    do_instr(32'h0000_0022, 0, 2, 0);          // store, same timing
    do_instr(32'h0000_004B, 0, 0, 0);          // taken branch to 0x40
    chk("taken_pc", pc_o, 32'h40);
    do_instr(32'h0000_0084, 0, 0, 0);          // JAL to 0x80
    chk("jal_pc", pc_o, 32'h80);
    do_instr(32'hABCD_0003, 0, 0, 0);          // not-taken branch at 0x80
    chk("not_taken_pc", pc_o, 32'h84);

    halt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halt_no_req", imem_req_o, 1'b0);
      chk("halt_state", state_o, 3'd0);
      @(negedge clk);
    end
    chk("halt_pc", pc_o, 32'h84);
    halt_i = 1'b0;
    do_instr(32'h0000_0000, 1, 0, 0);

    do_instr(32'hFFFF_FFF4, 0, 0, 0);          // JAL to 0xFFFF_FFF0
    for (int i = 0; i < 3; i++) do_instr(32'h5555_5555, 0, 0, 0);
    chk("pre_wrap_pc", pc_o, 32'hFFFF_FFFC);
    do_instr(32'h0000_0007, 0, 0, 0);
    chk("wrap_pc", pc_o, 32'h0);

    for (int n = 0; n < 40; n++) begin
      t = 3'($urandom_range(0, 6));
      if (t == 3'd6) t = 3'd7;
      do_instr({$urandom_range(0, 32'h1FFF_FFFF), t} , $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end

    // Reset while waiting for data: instruction abandoned.
    imem_rvalid_i = 1'b0;
    @(negedge clk); imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0011;
    @(negedge clk); imem_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_wait_d_state", state_o, 3'd5);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_state", state_o, 3'd0);
    chk("mid_rst_pc", pc_o, RPC);
    chk("mid_rst_retire", retire_o, 1'b0);
    chk("mid_rst_req", imem_req_o, 1'b0);
    rst_i = 1'b0;
    model_pc = RPC;
    do_instr(32'h0000_0005, 0, 0, 0);

`ifdef MCC_ILLEGAL_TRAP_EN
    @(negedge clk); imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0006;
    @(negedge clk); imem_rvalid_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("trap_o", trap_o, 1'b1);
      chk("trap_state", state_o, 3'd7);
      chk("trap_no_ireq", imem_req_o, 1'b0);
      chk("trap_no_dreq", dmem_req_o, 1'b0);
      chk("trap_pc", pc_o, model_pc);
      @(negedge clk);
    end
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("trap_cleared", trap_o, 1'b0);
    rst_i = 1'b0;
`else
    do_instr(32'h0000_0006, 0, 0, 0);          // illegal executes as NOP
    chk("illegal_nop_pc", pc_o, RPC + 32'd8);
    chk("no_trap", trap_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing FSM for the rv32 core. It owns the program counter and instruction register and steps each instruction through fetch, decode, execute, memory and writeback. It consumes the control fields produced by `instruction_decoder` and drives the enables of the register file, ALU result latch and memory ports. Exactly one instruction is in flight at a time.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `halt_i`  in  1  holds the core in FETCH without issuing a request.
- `imem_req_o`  out  1  instruction fetch request, one-cycle pulse.
- `imem_addr_o`  out  32  fetch address, equal to `pc_o`.
- `imem_rvalid_i`  in  1  fetch data valid.
- `imem_rdata_i`  in  32  fetched instruction word.
- `ir_o`  out  32  instruction register, feeds the decoder.
- `dec_valid_i`  in  1  decoder recognised the opcode.
- `dec_reg_write_i`, `dec_mem_read_i`, `dec_mem_write_i`, `dec_branch_i`, `dec_jump_i`  in  1 each  decoded control fields.
- `branch_taken_i`  in  1  branch comparison result from the datapath.
- `target_addr_i`  in  32  branch or jump target from the datapath.
- `dmem_req_o`  out  1  data memory request, one-cycle pulse.
- `dmem_we_o`  out  1  write qualifier, valid with `dmem_req_o`.
- `dmem_rvalid_i`  in  1  data access complete, for both loads and stores.
- `alu_en_o`  out  1  latch the ALU result.
- `rf_we_o`  out  1  register file write enable.
- `wb_sel_o`  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
- `pc_o`  out  32  current PC.
- `state_o`  out  3  current state encoding.
- `retire_o`  out  1  one-cycle pulse per completed instruction.
- `trap_o`  out  1  illegal-instruction trap; tied to 0 unless `MCC_ILLEGAL_TRAP_EN` is defined.

## Operation
- State encodings: FETCH=0, WAIT_I=1, DECODE=2, EXECUTE=3, MEM=4, WAIT_D=5, WB=6, TRAP=7.
- **FETCH**
  - If `halt_i`=1: no request, stay in FETCH.
  - Otherwise: pulse `imem_req_o`, go to WAIT_I.
- **WAIT_I**
  - Stay until `imem_rvalid_i`=1.
  - On that cycle, load `ir_o` from `imem_rdata_i` and go to DECODE.
  - `imem_rvalid_i` is ignored in every other state.
- **DECODE**: one cycle; the decoder outputs settle from `ir_o`.
  - `dec_valid_i`=0 is the illegal case. It goes to TRAP when the trap macro is defined (see Configuration).
  - Otherwise go to EXECUTE.
- **EXECUTE**: `alu_en_o`=1 for one cycle.
  - If `dec_mem_read_i` or `dec_mem_write_i` is set: go to MEM.
  - Otherwise: go to WB.
- **MEM**: pulse `dmem_req_o`, with `dmem_we_o`=`dec_mem_write_i`; go to WAIT_D.
- **WAIT_D**: stay until `dmem_rvalid_i`=1, then go to WB.
- **WB**: one cycle.
  - `rf_we_o`=`dec_reg_write_i`.
  - `wb_sel_o` = 10 if jump, 01 if load, else 00.
  - `retire_o`=1.
  - PC update: PC ← `target_addr_i` if (jump) or (branch and `branch_taken_i`); else PC+4.
  - Go to FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Targets are used unmodified; alignment is the datapath's responsibility.
- All outputs not listed for a state are 0 in that state.
- Reset: state=FETCH, `pc_o`=`RESET_PC`, `ir_o`=0, all strobes 0, `trap_o`=0.
  - Reset wins over every other event.
  - Reset asserted mid-transaction abandons the instruction; memories are reset on the same `rst_i`.

## Timing
- `imem_rvalid_i` is expected no earlier than the cycle after `imem_req_o`.
- `dmem_rvalid_i` is expected no earlier than the cycle after `dmem_req_o`.
- With zero-wait memory (rvalid one cycle after req):
  - ALU, branch or jump instruction: 5 cycles (FETCH, WAIT_I, DECODE, EXECUTE, WB).
  - Load or store: 7 cycles.
- Each memory wait cycle adds one cycle.
- `retire_o` and the PC update share the WB edge; the next FETCH presents the new PC.
- `halt_i` is sampled only in FETCH. An instruction in flight always completes.

## Configuration
- `MCC_ILLEGAL_TRAP_EN` defined:
  - `dec_valid_i`=0 in DECODE → TRAP.
  - TRAP is sticky until reset: `trap_o`=1, no memory requests, PC frozen at the faulting address.
- Not defined:
  - An illegal instruction executes as a NOP: EXECUTE → WB, `rf_we_o`=0, PC+4, `retire_o` pulses.
  - `trap_o` is constant 0 and state 7 is unreachable.

## Test plan
- **Reset, then ADDI**: `RESET_PC`=0x100, `imem_rvalid_i` one cycle after each request.
  - First `imem_addr_o`=0x100.
  - `retire_o` on cycle 5 with `rf_we_o`=1, `wb_sel_o`=00.
  - Next fetch at 0x104.
- **Load with a 3-cycle data wait**: `retire_o` on cycle 9, `wb_sel_o`=01. A store on the same timing gives `rf_we_o`=0 and `dmem_we_o`=1.
- **Branches**:
  - Taken branch, target 0x40: next fetch address 0x40.
  - Not-taken branch at 0x80: next fetch address 0x84.
  - JAL: `wb_sel_o`=10 and PC=target.
- **Halt and wrap**:
  - `halt_i`=1 held for 10 cycles: no `imem_req_o`; fetch resumes the cycle `halt_i` drops.
  - PC 0xFFFF_FFFC non-branch: PC wraps to 0.
- **Reset mid-instruction**: `rst_i` asserted in WAIT_D → next cycle state=FETCH, `pc_o`=`RESET_PC`, no `retire_o`.
- **Illegal instruction**: `dec_valid_i`=0.
  - Macro defined: `trap_o`=1 is sticky and no further requests are issued.
  - Macro undefined: NOP retire, PC+4.
